ibus_cbus_responder: RTL and testbench

Responder end of the instruction bus: accepts `ibus_req_t` requests from the fetch stage and returns `ibus_resp_t` instruction words, servicing each request as one single-beat 8-byte read on the `cbus` toward the memory interconnect. Sits between `fetch` and the cbus arbiter. It holds one request in flight, discards responses whose address the fetch stage has abandoned, and optionally keeps a one-entry line buffer so consecutive fetches from the same 8-byte word complete without a bus transaction.

---
 rtl/common.sv | 45 ++++
 rtl/ibus_cbus_responder.sv | 140 ++++++++++++++
 tb/tb_ibus_cbus_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/common.sv
// common: shared bus bundle types for the ibus and cbus.
// Holds request/response structs and cbus encoding constants.
package common;

  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;
  typedef logic [1:0] axi_burst_type_t;

  localparam msize_t          MSIZE1 = 3'd0;
  localparam msize_t          MSIZE2 = 3'd1;
  localparam msize_t          MSIZE4 = 3'd2;
  localparam msize_t          MSIZE8 = 3'd3;
  localparam mlen_t           MLEN1  = 4'd0;
  localparam axi_burst_type_t AXI_BURST_FIXED = 2'd0;
  localparam axi_burst_type_t AXI_BURST_INCR  = 2'd1;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/ibus_cbus_responder.sv
// ibus_cbus_responder: serves ibus fetches as single-beat cbus reads.
// Optional one-entry line buffer enabled by `IBUS_LINEBUF_EN.
module ibus_cbus_responder
  import common::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] lat_addr_q, lat_addr_d;
  logic [63:0] rdata_q, rdata_d;
  logic        done;
  logic        hit;
  logic        accept;
  logic [63:0] hit_data;

  assign done   = cresp.ready && cresp.last;
  assign accept = (state_q == IDLE) && ireq.valid && !hit;

`ifdef IBUS_LINEBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;

  assign hit = ireq.valid && buf_valid_q
            && (ireq.addr[63:3] == buf_tag_q);
  assign hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (state_q == FETCH && done) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = lat_addr_q[63:3];
      buf_data_d  = cresp.data;
    end
    // invalidation must beat a fill landing on the same edge
    if (flush) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign hit_data     = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      lat_addr_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = FETCH;
          lat_addr_d = ireq.addr;
        end
      end
      FETCH: begin
        if (done) begin
          state_d = RESP;
          rdata_d = cresp.data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iresp = '0;
    creq  = '0;
    unique case (state_q)
      IDLE: begin
        iresp.addr_ok = accept;
        if ((state_q == IDLE) && hit) begin
          iresp.data_ok = 1'b1;
          iresp.data    = ireq.addr[2] ? hit_data[63:32]
                                       : hit_data[31:0];
        end
      end
      FETCH: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.size     = MSIZE8;
        creq.len      = MLEN1;
        creq.burst    = AXI_BURST_FIXED;
        creq.strobe   = '0;
        creq.addr     = {lat_addr_q[63:3], 3'b000};
      end
      RESP: begin
        // fetch may have moved on; only answer the address it still wants
        if (ireq.valid && (ireq.addr == lat_addr_q)) begin
          iresp.data_ok = 1'b1;
          iresp.data    = lat_addr_q[2] ? rdata_q[63:32]
                                        : rdata_q[31:0];
        end
      end
      default: ;
    endcase
    if (!reset) iresp = '0;
  end

endmodule

// File: tb/tb_ibus_cbus_responder.sv
// tb_ibus_cbus_responder: directed scoreboard bench for ibus_cbus_responder.
// Buffer-specific vectors run only when IBUS_LINEBUF_EN is defined.
module tb_ibus_cbus_responder;
  import common::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  ibus_cbus_responder dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .creq  (creq),
    .cresp (cresp),
    .flush (flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } dexp_t;

  dexp_t       dq[$];
  logic [63:0] aq[$];

  // memory model: ready&last after mem_wait stall cycles
  int          mem_wait = 0;
  logic [63:0] mem_data = '0;
  int          mcnt = 0;

  always @(negedge clk) begin
    if (creq.valid === 1'b1) begin
      cresp.ready = (mcnt == mem_wait);
      cresp.last  = (mcnt == mem_wait);
      cresp.data  = mem_data;
      mcnt++;
    end else begin
      cresp.ready = 1'b0;
      cresp.last  = 1'b0;
      cresp.data  = '0;
      mcnt = 0;
    end
  end

  // monitor: pops expectations when the DUT presents responses
  bit          prev_v = 1'b0;
  logic [63:0] cur_a = '0;

  always @(negedge clk) begin
    dexp_t e;
    if (iresp.data_ok === 1'b1) begin
      if (dq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious data_ok: got data %h cyc %0d, required none",
                 iresp.data, cyc);
      end else begin
        e = dq.pop_front();
        check("data_ok cycle", 64'(cyc), 64'(e.cyc));
        check("data_ok data", 64'(iresp.data), 64'(e.data));
      end
      check("addr_ok with data_ok", 64'(iresp.addr_ok), 64'd0);
    end else begin
      check("data zero when idle", 64'(iresp.data), 64'd0);
    end
    if (creq.valid === 1'b1) begin
      if (!prev_v) begin
        if (aq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious creq: got addr %h, required none",
                   creq.addr);
          cur_a = creq.addr;
        end else begin
          cur_a = aq.pop_front();
        end
      end
      check("creq.addr", creq.addr, cur_a);
      check("creq.is_write", 64'(creq.is_write), 64'd0);
      check("creq.size", 64'(creq.size), 64'd3);
      check("creq.len", 64'(creq.len), 64'd0);
      check("creq.burst", 64'(creq.burst), 64'd0);
      check("creq.strobe", 64'(creq.strobe), 64'd0);
    end
    prev_v = (creq.valid === 1'b1);
  end

  task automatic wait_dok();
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (iresp.data_ok === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL data_ok timeout: got none, required pulse");
    end
    @(posedge clk);
    #1;
    ireq.valid = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a, input int w,
                       input logic [63:0] d, input bit miss,
                       input logic [31:0] exp);
    dexp_t e;
    mem_wait   = w;
    mem_data   = d;
    ireq.valid = 1'b1;
    ireq.addr  = a;
    e.data = exp;
    if (miss) begin
      aq.push_back({a[63:3], 3'b000});
      e.cyc = cyc + 2 + w;
    end else begin
      e.cyc = cyc;
    end
    dq.push_back(e);
    wait_dok();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required end of test");
    $fatal(1);
  end

  initial begin
    dexp_t e;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0000;
    cresp      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset creq.valid", 64'(creq.valid), 64'd0);
    check("reset data_ok", 64'(iresp.data_ok), 64'd0);
    check("reset addr_ok", 64'(iresp.addr_ok), 64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    mem_wait = 0;
    mem_data = 64'h1111_2222_3333_4444;
    aq.push_back(64'h8000_0000);
    e.cyc  = cyc + 2;
    e.data = 32'h3333_4444;
    dq.push_back(e);
    wait_dok();

    do_flush();
    fetch(64'h8000_0004, 0, 64'h1111_2222_3333_4444,
          1'b1, 32'h1111_2222);

    // fetch abandons 0x80000000 mid-flight in favour of 0x80000100
    do_flush();
    mem_wait   = 3;
    mem_data   = 64'h5555_6666_7777_8888;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0000;
    aq.push_back(64'h8000_0000);
    e.cyc  = cyc + 11;
    e.data = 32'h7777_8888;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    ireq.addr = 64'h8000_0100;
    aq.push_back(64'h8000_0100);
    dq.push_back(e);
    wait_dok();

    do_flush();
    fetch(64'h8000_0106, 2, 64'h9999_AAAA_BBBB_CCCC,
          1'b1, 32'h9999_AAAA);

`ifdef IBUS_LINEBUF_EN
    do_flush();
    fetch(64'h8000_0000, 0, 64'h1111_2222_3333_4444,
          1'b1, 32'h3333_4444);
    fetch(64'h8000_0004, 0, 64'h1111_2222_3333_4444,
          1'b0, 32'h1111_2222);
    do_flush();
    fetch(64'h8000_0004, 0, 64'hAAAA_BBBB_CCCC_DDDD,
          1'b1, 32'hAAAA_BBBB);
`endif

    // reset lands while a read is outstanding
    mem_wait   = 10;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0040;
    aq.push_back(64'h8000_0040);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("fetch creq.valid", 64'(creq.valid), 64'd1);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    ireq.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset mid-fetch creq.valid", 64'(creq.valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fetch(64'h8000_0004, 1, 64'hDEAD_BEEF_0BAD_F00D,
          1'b1, 32'hDEAD_BEEF);

    repeat (4) @(posedge clk);
    check("data queue drained", 64'(dq.size()), 64'd0);
    check("creq queue drained", 64'(aq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
